// File: rtl/block_push_ctl_pkg.sv
// Shared play-field definitions: arena bounds, block geometry, push direction
// encoding and the push controller state encoding.
package block_push_ctl_pkg;

    localparam int POS_W          = 12;
    localparam int ARITH_W        = 13;

    localparam int SQUARE_SIDE    = 60;
    localparam int PUSH_DIST_DEF  = 60;
    localparam int ARENA_X_MIN    = 62;
    localparam int ARENA_X_MAX    = 962;
    localparam int ARENA_Y_MIN    = 108;
    localparam int ARENA_Y_MAX    = 708;
    localparam int BLOCK_INIT_X   = 302;
    localparam int BLOCK_INIT_Y   = 348;
    localparam int COOLDOWN_DEF   = 16;

    // Bit 1 set means the push increases the coordinate; bits differing means horizontal.
    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_RIGHT = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_PUSH     = 2'b01,
        ST_COOLDOWN = 2'b10
    } state_t;

    function automatic logic signed [ARITH_W-1:0] to_s13(input logic [POS_W-1:0] v);
        return $signed({1'b0, v});
    endfunction

    function automatic logic signed [ARITH_W-1:0] abs13(input logic signed [ARITH_W-1:0] v);
        return v[ARITH_W-1] ? -v : v;
    endfunction

endpackage

// File: rtl/block_push_ctl_if.sv
// Hero/block link: hero position, collision and step rate in; block position
// and push status back out.
interface block_push_ctl_if;
    import block_push_ctl_pkg::*;

    logic             step_tick;
    logic [3:0]       collision;
    logic [POS_W-1:0] hero_x;
    logic [POS_W-1:0] hero_y;
    logic [POS_W-1:0] block_x_pos;
    logic [POS_W-1:0] block_y_pos;
    logic             busy;
    dir_t             push_dir;
    logic             push_done;
    logic             push_blocked;

    modport master (
        output step_tick, collision, hero_x, hero_y,
        input  block_x_pos, block_y_pos, busy, push_dir, push_done, push_blocked
    );

    modport slave (
        input  step_tick, collision, hero_x, hero_y,
        output block_x_pos, block_y_pos, busy, push_dir, push_done, push_blocked
    );

endinterface

// File: rtl/block_push_ctl_push_dir_sel.sv
// Combinational push decision: picks the push axis/direction from the hero
// offset and checks the one-cell target against the arena bounds.
module push_dir_sel
    import block_push_ctl_pkg::*;
#(
    parameter int PUSH_DIST = PUSH_DIST_DEF,
    parameter int X_MIN     = ARENA_X_MIN,
    parameter int X_MAX     = ARENA_X_MAX,
    parameter int Y_MIN     = ARENA_Y_MIN,
    parameter int Y_MAX     = ARENA_Y_MAX
) (
    input  logic [POS_W-1:0]          hero_x,
    input  logic [POS_W-1:0]          hero_y,
    input  logic [POS_W-1:0]          block_x,
    input  logic [POS_W-1:0]          block_y,
    output dir_t                      dir,
    output logic signed [ARITH_W-1:0] target,
    output logic                      blocked
);

    localparam logic signed [ARITH_W-1:0] DIST = ARITH_W'(PUSH_DIST);
    localparam logic signed [ARITH_W-1:0] XLO  = ARITH_W'(X_MIN);
    localparam logic signed [ARITH_W-1:0] XHI  = ARITH_W'(X_MAX);
    localparam logic signed [ARITH_W-1:0] YLO  = ARITH_W'(Y_MIN);
    localparam logic signed [ARITH_W-1:0] YHI  = ARITH_W'(Y_MAX);

    logic signed [ARITH_W-1:0] dx;
    logic signed [ARITH_W-1:0] dy;
    logic signed [ARITH_W-1:0] lo;
    logic signed [ARITH_W-1:0] hi;

    always_comb begin
        dx = to_s13(block_x) - to_s13(hero_x);
        dy = to_s13(block_y) - to_s13(hero_y);
        // A tie on magnitude favours the horizontal axis.
        if (abs13(dx) >= abs13(dy)) begin
            dir    = dx[ARITH_W-1] ? DIR_LEFT : DIR_RIGHT;
            target = dx[ARITH_W-1] ? to_s13(block_x) - DIST : to_s13(block_x) + DIST;
            lo     = XLO;
            hi     = XHI;
        end else begin
            dir    = dy[ARITH_W-1] ? DIR_UP : DIR_DOWN;
            target = dy[ARITH_W-1] ? to_s13(block_y) - DIST : to_s13(block_y) + DIST;
            lo     = YLO;
            hi     = YHI;
        end
        blocked = (target < lo) || (target > hi);
    end

endmodule

// File: rtl/block_push_ctl.sv
// Pushable block controller: decides a push on hero contact, slides the block
// one cell at the step rate, then waits for contact to clear before re-arming.
module block_push_ctl
    import block_push_ctl_pkg::*;
#(
    parameter int PUSH_DIST      = PUSH_DIST_DEF,
    parameter int X_MIN          = ARENA_X_MIN,
    parameter int X_MAX          = ARENA_X_MAX,
    parameter int Y_MIN          = ARENA_Y_MIN,
    parameter int Y_MAX          = ARENA_Y_MAX,
    parameter int INIT_X         = BLOCK_INIT_X,
    parameter int INIT_Y         = BLOCK_INIT_Y,
    parameter int COOLDOWN_TICKS = COOLDOWN_DEF
) (
    input  logic             clk,
    input  logic             rst,
    block_push_ctl_if.slave  bus
);

    localparam int               CNT_W   = $clog2(COOLDOWN_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(COOLDOWN_TICKS);

    state_t                    state;
    state_t                    state_nxt;
    logic [POS_W-1:0]          pos_x;
    logic [POS_W-1:0]          pos_y;
    logic signed [ARITH_W-1:0] target;
    logic [CNT_W-1:0]          cnt;
    dir_t                      dir_q;
    logic                      done_q;
    logic                      blocked_q;

    dir_t                      sel_dir;
    logic signed [ARITH_W-1:0] sel_target;
    logic                      sel_blocked;

    logic                      contact;
    logic                      horiz;
    logic signed [ARITH_W-1:0] cur;
    logic signed [ARITH_W-1:0] moved;
    logic                      arrive;
    logic                      latch_push;
    logic                      move;
    logic                      done_nxt;
    logic                      blocked_nxt;
    logic                      unused_bits;

    push_dir_sel #(
        .PUSH_DIST (PUSH_DIST),
        .X_MIN     (X_MIN),
        .X_MAX     (X_MAX),
        .Y_MIN     (Y_MIN),
        .Y_MAX     (Y_MAX)
    ) u_sel (
        .hero_x  (bus.hero_x),
        .hero_y  (bus.hero_y),
        .block_x (pos_x),
        .block_y (pos_y),
        .dir     (sel_dir),
        .target  (sel_target),
        .blocked (sel_blocked)
    );

    assign contact     = bus.collision[0];
    assign unused_bits = ^{bus.collision[3:1], moved[ARITH_W-1]};

    // One-pixel step toward the latched target on the latched axis.
    assign horiz  = dir_q[1] ^ dir_q[0];
    assign cur    = horiz ? to_s13(pos_x) : to_s13(pos_y);
    assign moved  = dir_q[1] ? cur + 13'sd1 : cur - 13'sd1;
    assign arrive = (moved == target);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:     if (contact) state_nxt = sel_blocked ? ST_COOLDOWN : ST_PUSH;
            ST_PUSH:     if (bus.step_tick && arrive) state_nxt = ST_COOLDOWN;
            ST_COOLDOWN: if (cnt == CNT_MAX) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        latch_push  = (state == ST_IDLE) && contact && !sel_blocked;
        blocked_nxt = (state == ST_IDLE) && contact && sel_blocked;
        move        = (state == ST_PUSH) && bus.step_tick;
        done_nxt    = move && arrive;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_x     <= POS_W'(INIT_X);
            pos_y     <= POS_W'(INIT_Y);
            target    <= '0;
            dir_q     <= DIR_UP;
            done_q    <= 1'b0;
            blocked_q <= 1'b0;
            cnt       <= '0;
        end else begin
            done_q    <= done_nxt;
            blocked_q <= blocked_nxt;
            if (latch_push) begin
                dir_q  <= sel_dir;
                target <= sel_target;
            end
            if (move) begin
                if (horiz) pos_x <= moved[POS_W-1:0];
                else       pos_y <= moved[POS_W-1:0];
            end
            // Counter is held at zero outside COOLDOWN so every entry starts fresh.
            if (state != ST_COOLDOWN)    cnt <= '0;
            else if (contact)            cnt <= '0;
            else if (bus.step_tick && cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end
    end

    assign bus.block_x_pos  = pos_x;
    assign bus.block_y_pos  = pos_y;
    assign bus.busy         = (state == ST_PUSH);
    assign bus.push_dir     = dir_q;
    assign bus.push_done    = done_q;
    assign bus.push_blocked = blocked_q;

endmodule

// File: doc/block_push_ctl.md
# block_push_ctl

Pushable-block controller for the play field. It consumes the hero position and the held collision flag from the hero controller. It drives block_x_pos/block_y_pos back to that controller, closing the hero/block collision loop. On contact it decides a push direction and slides the block one grid cell at the game step rate, refusing pushes that would leave the arena.

## Interface
- SQUARE_SIDE, 60: sprite/block side in pixels
- PUSH_DIST, 60: pixels moved per push (one cell)
- X_MIN, 62 / X_MAX, 962: legal block x range, inclusive
- Y_MIN, 108 / Y_MAX, 708: legal block y range, inclusive
- INIT_X, 302 / INIT_Y, 348: block position after reset
- COOLDOWN_TICKS, 16: step ticks of no-contact required before re-arming

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- step_tick  in  1  one-clk strobe at movement rate (one pixel per tick)
- collision  in  4  held collision flags; only bit 0 (overlap) is used
- hero_x, hero_y  in  12 each  hero top-left, pixels, unsigned
- block_x_pos, block_y_pos  out  12 each  block top-left, registered
- busy  out  1  high while in PUSH
- push_dir  out  2  latched direction: 00 up, 01 left, 10 right, 11 down
- push_done  out  1  one-clk pulse when a push completes
- push_blocked  out  1  one-clk pulse when a push is rejected by bounds

## Operation
- States: IDLE, PUSH, COOLDOWN.
- IDLE, collision[0]=1:
  - dx = block_x − hero_x and dy = block_y − hero_y, both 13-bit signed.
  - |dx| ≥ |dy| selects a horizontal push; a tie goes horizontal. dx ≥ 0 → right, else left.
  - A vertical push is down when dy ≥ 0, else up.
  - Target = block ± PUSH_DIST on the chosen axis, computed 13-bit signed.
  - Target inside [MIN, MAX]: latch push_dir and target, then go to PUSH.
  - Target outside the range: pulse push_blocked, position unchanged, go to COOLDOWN.
- PUSH:
  - Each step_tick moves the block 1 pixel toward the target.
  - On the tick where position equals the target, go to COOLDOWN and pulse push_done.
  - collision is ignored in this state.
- COOLDOWN:
  - The counter resets to 0 on entry.
  - It increments on each step_tick while collision[0]=0 and clears whenever collision[0]=1.
  - Go to IDLE when the counter reaches COOLDOWN_TICKS.
- All arithmetic is 13-bit signed internally. Outputs are 12-bit unsigned and never leave [MIN, MAX].

## Timing
- Reset values: block_x_pos=INIT_X, block_y_pos=INIT_Y, busy=0, push_dir=00, push_done=0, push_blocked=0, state IDLE, counter 0.
- Direction decision: 1 clk after collision[0] is sampled high in IDLE. busy rises on that same edge.
- A step_tick coincident with the IDLE→PUSH edge does not move the block. The first move happens on the next step_tick.
- A full push takes exactly PUSH_DIST step_ticks after entering PUSH.
- push_done rises on the edge that writes the final position and clears 1 clk later. busy falls on the same edge push_done rises.
- push_blocked is high for 1 clk on the IDLE→COOLDOWN edge.
- Rearm latency: at least COOLDOWN_TICKS step_ticks after contact ends.
- rst mid-PUSH or mid-COOLDOWN: immediate return to the reset values. A partially completed move is discarded.
- step_tick held high for multiple clks counts once per clk; the source must strobe.

## Structure
- Shared game package: SQUARE_SIDE, arena bounds, the direction encoding (UP/LEFT/RIGHT/DOWN), and this block's state encoding. The hero controller uses the same bounds and square size.
- One sub-module, push_dir_sel: combinational. Inputs are hero and block positions; outputs are direction, target, and a blocked flag.
- The FSM, position registers, and cooldown counter stay in block_push_ctl.

## Test plan
- Reset with default parameters → block (302,348), busy=0, no pulses; positions stay there over 100 step_ticks with collision=0.
- Hero (250,348), collision[0]=1 → push_dir=10, busy=1. After 60 step_ticks block_x_pos=362, block_y_pos=348, one push_done pulse, busy=0.
- Hero (302,300), collision=1 → push_dir=11. block_y_pos steps 348→408 in 60 ticks; block_x_pos is unchanged.
- INIT_X=92, hero (140,348), collision=1 → target 32 < 62. Result: push_blocked pulse, block stays at (92,348), busy never asserted.
- rst asserted after 20 step_ticks of a right push (block_x=322) → block back to (302,348), state IDLE, busy=0 in the same cycle.
- Collision held high for 200 ticks after a push completes → no second push. Collision then drops → a new push is accepted only after 16 further step_ticks.
